rob_sequencer: RTL and testbench

//  Controller for the ROB. Gates dispatch pushes and round-robin arbitrates NUM_FU completion requests onto the single finish port.

---
 rtl/rob_sequencer_if.sv | 65 ++++++
 rtl/rob_sequencer.sv | 148 ++++++++++++++
 tb/tb_rob_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/rob_sequencer_if.sv
// ============================================================================
//  Module      : rob_sequencer_if
//  Description : Dispatch, completion, commit, flush and ROB-side signals of
//                the ROB sequencer, bundled into one interface.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rob_sequencer_if #(
    parameter int NUM_FU = 4,
    parameter int W      = 32
);
    logic                disp_valid;
    logic [W-1:0]        disp_instr;
    logic                disp_ready;
    logic [NUM_FU-1:0]   fu_valid;
    logic [NUM_FU*W-1:0] fu_instr;
    logic [NUM_FU*W-1:0] fu_val;
    logic [NUM_FU-1:0]   fu_grant;
    logic                commit_ready;
    logic                commit_valid;
    logic [W-1:0]        commit_instr;
    logic [W-1:0]        commit_val;
    logic                flush_req;
    logic [W-1:0]        flush_instr;
    logic                busy;
    logic [31:0]         commit_count;
    logic                rob_push;
    logic [W-1:0]        rob_instr_in;
    logic                rob_finishing_instr;
    logic [W-1:0]        rob_instr_to_finish;
    logic [W-1:0]        rob_finish_val;
    logic                rob_pop;
    logic                rob_flushing_instr;
    logic [W-1:0]        rob_instr_to_flush;
    logic [W-1:0]        rob_head_instr;
    logic [W-1:0]        rob_head_val;
    logic                rob_head_ready;
    logic                rob_is_empty;
    logic                rob_is_full;

    // Environment side: front end, functional units, commit sink and ROB model
    modport master (
        output disp_valid, disp_instr, fu_valid, fu_instr, fu_val,
        output commit_ready, flush_req, flush_instr,
        output rob_head_instr, rob_head_val, rob_head_ready, rob_is_empty, rob_is_full,
        input  disp_ready, fu_grant, commit_valid, commit_instr, commit_val,
        input  busy, commit_count, rob_push, rob_instr_in, rob_finishing_instr,
        input  rob_instr_to_finish, rob_finish_val, rob_pop,
        input  rob_flushing_instr, rob_instr_to_flush
    );

    // Sequencer side
    modport slave (
        input  disp_valid, disp_instr, fu_valid, fu_instr, fu_val,
        input  commit_ready, flush_req, flush_instr,
        input  rob_head_instr, rob_head_val, rob_head_ready, rob_is_empty, rob_is_full,
        output disp_ready, fu_grant, commit_valid, commit_instr, commit_val,
        output busy, commit_count, rob_push, rob_instr_in, rob_finishing_instr,
        output rob_instr_to_finish, rob_finish_val, rob_pop,
        output rob_flushing_instr, rob_instr_to_flush
    );
endinterface

`default_nettype wire

// File: rtl/rob_sequencer.sv
// ============================================================================
//  Module      : rob_sequencer
//  Description : ROB controller - dispatch gating, round-robin completion
//                arbitration, head commit and flush/recovery sequencing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_sequencer #(
    parameter int NUM_FU       = 4,
    parameter int W            = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  wire logic       clock,
    input  wire logic       reset,
    rob_sequencer_if.slave  bus
);
    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [CNT_W-1:0] c_wait_init = CNT_W'(FLUSH_CYCLES - 1);

    logic [1:0]        r_state,      w_state_nxt;
    logic [PTR_W-1:0]  r_rr_ptr,     w_rr_ptr_nxt;
    logic [W-1:0]      r_flush_tag,  w_flush_tag_nxt;
    logic [CNT_W-1:0]  r_wait_cnt,   w_wait_cnt_nxt;
    logic [31:0]       r_commit_count;

    logic              w_go;
    logic [NUM_FU-1:0] w_grant;
    logic [PTR_W-1:0]  w_grant_idx;
    logic              w_found;
    logic [PTR_W:0]    w_idx;
    logic [W-1:0]      w_fin_instr;
    logic [W-1:0]      w_fin_val;
    logic              w_commit_valid;

    // A flush request in RUN steals the cycle from dispatch, completion and commit
    assign w_go = (r_state == S_RUN) && !bus.flush_req;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_RUN;
            r_rr_ptr       <= '0;
            r_flush_tag    <= '0;
            r_wait_cnt     <= '0;
            r_commit_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_flush_tag <= w_flush_tag_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            if (bus.rob_pop) begin
                r_commit_count <= r_commit_count + 32'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_tag_nxt = r_flush_tag;
        w_wait_cnt_nxt  = r_wait_cnt;
        case (r_state)
            S_RUN: begin
                if (bus.flush_req) begin
                    w_state_nxt     = S_FLUSH;
                    w_flush_tag_nxt = bus.flush_instr;
                end
            end
            S_FLUSH: begin
                w_state_nxt    = S_WAIT;
                w_wait_cnt_nxt = c_wait_init;
            end
            S_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 1'b1;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Scan requesters starting at the round-robin pointer, wrapping at NUM_FU
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        w_idx       = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            w_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(i);
            if (w_idx >= (PTR_W+1)'(NUM_FU)) begin
                w_idx = w_idx - (PTR_W+1)'(NUM_FU);
            end
            if (w_go && !w_found && bus.fu_valid[w_idx[PTR_W-1:0]]) begin
                w_found     = 1'b1;
                w_grant_idx = w_idx[PTR_W-1:0];
            end
        end
        if (w_found) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    always_comb begin
        w_rr_ptr_nxt = r_rr_ptr;
        if (w_found) begin
            w_rr_ptr_nxt = (w_grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : w_grant_idx + 1'b1;
        end
    end

    always_comb begin
        w_fin_instr = '0;
        w_fin_val   = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_grant[i]) begin
                w_fin_instr = w_fin_instr | bus.fu_instr[i*W +: W];
                w_fin_val   = w_fin_val   | bus.fu_val[i*W +: W];
            end
        end
    end

    assign w_commit_valid = w_go && bus.rob_head_ready && !bus.rob_is_empty;

    assign bus.disp_ready          = w_go && !bus.rob_is_full;
    assign bus.rob_push            = bus.disp_valid && bus.disp_ready;
    assign bus.rob_instr_in        = bus.disp_instr;
    assign bus.fu_grant            = w_grant;
    assign bus.rob_finishing_instr = w_found;
    assign bus.rob_instr_to_finish = w_fin_instr;
    assign bus.rob_finish_val      = w_fin_val;
    assign bus.commit_valid        = w_commit_valid;
    assign bus.commit_instr        = bus.rob_head_instr;
    assign bus.commit_val          = bus.rob_head_val;
    assign bus.rob_pop             = w_commit_valid && bus.commit_ready;
    assign bus.commit_count        = r_commit_count;
    assign bus.rob_flushing_instr  = (r_state == S_FLUSH);
    assign bus.rob_instr_to_flush  = r_flush_tag;
    assign bus.busy                = (r_state != S_RUN);

endmodule

`default_nettype wire

// File: tb/tb_rob_sequencer.sv
// ============================================================================
//  Module      : tb_rob_sequencer
//  Description : Directed self-checking bench for rob_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rob_sequencer;
    localparam int NUM_FU = 4;
    localparam int W      = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [W-1:0]      q_push[$];
    logic [NUM_FU-1:0] q_grant[$];
    logic [W-1:0]      q_fin[$];
    logic [W-1:0]      q_commit[$];

    logic [W-1:0]      exp_w;
    logic [NUM_FU-1:0] exp_g;

    always #5 clk = ~clk;

    rob_sequencer_if #(.NUM_FU(NUM_FU), .W(W)) bus ();

    rob_sequencer #(.NUM_FU(NUM_FU), .W(W), .FLUSH_CYCLES(2)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.disp_valid = 0; bus.disp_instr = '0;
        bus.fu_valid = '0;  bus.fu_instr = '0; bus.fu_val = '0;
        bus.commit_ready = 0; bus.flush_req = 0; bus.flush_instr = '0;
        bus.rob_head_instr = '0; bus.rob_head_val = '0;
        bus.rob_head_ready = 0; bus.rob_is_empty = 1; bus.rob_is_full = 0;
        for (int i = 0; i < NUM_FU; i++) begin
            bus.fu_instr[i*W +: W] = 32'h10 + i;
            bus.fu_val[i*W +: W]   = 32'h100 + i;
        end
        tick(); tick();
        rst = 0;

        sample();
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_flushing", 64'(bus.rob_flushing_instr), 64'd0);
        check("rst_count", 64'(bus.commit_count), 64'd0);
        check("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
        tick();

        // Dispatch of tags 1,2,3
        for (int t = 1; t <= 3; t++) begin
            bus.disp_valid = 1; bus.disp_instr = W'(t);
            q_push.push_back(W'(t));
            sample();
            check("push_valid", 64'(bus.rob_push), 64'd1);
            if (bus.rob_push) begin
                exp_w = q_push.pop_front();
                check("push_tag", 64'(bus.rob_instr_in), 64'(exp_w));
            end
            tick();
        end
        bus.rob_is_full = 1;
        sample();
        check("full_disp_ready", 64'(bus.disp_ready), 64'd0);
        check("full_push", 64'(bus.rob_push), 64'd0);
        tick();
        bus.disp_valid = 0; bus.rob_is_full = 0;

        // Round-robin with all four requesting, then wrap cases
        bus.fu_valid = 4'b1111;
        for (int g = 0; g < NUM_FU; g++) begin
            q_grant.push_back(NUM_FU'(1) << g);
            q_fin.push_back(32'h10 + g);
        end
        for (int c = 0; c < NUM_FU; c++) begin
            sample();
            check("rr_finishing", 64'(bus.rob_finishing_instr), 64'd1);
            if (bus.rob_finishing_instr) begin
                exp_g = q_grant.pop_front();
                exp_w = q_fin.pop_front();
                check("rr_grant", 64'(bus.fu_grant), 64'(exp_g));
                check("rr_tag", 64'(bus.rob_instr_to_finish), 64'(exp_w));
                check("rr_val", 64'(bus.rob_finish_val), 64'(exp_w + 32'hF0));
            end
            tick();
        end
        bus.fu_valid = 4'b1000;
        sample();
        check("wrap_grant3", 64'(bus.fu_grant), 64'b1000);
        tick();
        bus.fu_valid = 4'b1001;
        sample();
        check("wrap_grant0", 64'(bus.fu_grant), 64'b0001);
        check("wrap_tag0", 64'(bus.rob_instr_to_finish), 64'h10);
        tick();
        sample();
        check("wrap_grant3b", 64'(bus.fu_grant), 64'b1000);
        check("wrap_val3", 64'(bus.rob_finish_val), 64'h103);
        tick();
        bus.fu_valid = '0;
        sample();
        check("idle_grant", 64'(bus.fu_grant), 64'd0);
        check("idle_finishing", 64'(bus.rob_finishing_instr), 64'd0);
        check("idle_tag", 64'(bus.rob_instr_to_finish), 64'd0);
        check("idle_val", 64'(bus.rob_finish_val), 64'd0);
        tick();

        // Commit with back-pressure 0,0,1
        bus.rob_head_ready = 1; bus.rob_is_empty = 0;
        bus.rob_head_instr = 32'd7; bus.rob_head_val = 32'd42;
        for (int c = 0; c < 3; c++) begin
            bus.commit_ready = (c == 2);
            if (c == 2) q_commit.push_back(32'd7);
            sample();
            check("cm_valid", 64'(bus.commit_valid), 64'd1);
            check("cm_val", 64'(bus.commit_val), 64'd42);
            check("cm_pop", 64'(bus.rob_pop), 64'(c == 2));
            if (bus.rob_pop) begin
                exp_w = q_commit.pop_front();
                check("cm_tag", 64'(bus.commit_instr), 64'(exp_w));
            end
            tick();
        end
        bus.commit_ready = 0;
        sample();
        check("cm_count1", 64'(bus.commit_count), 64'd1);
        bus.rob_is_empty = 1;
        #1;
        check("cm_empty", 64'(bus.commit_valid), 64'd0);
        tick();

        // Flush with everything else active
        bus.rob_is_empty = 0; bus.commit_ready = 1;
        bus.disp_valid = 1; bus.disp_instr = 32'd20; bus.fu_valid = 4'b1111;
        bus.flush_req = 1; bus.flush_instr = 32'd5;
        sample();
        check("fl_push", 64'(bus.rob_push), 64'd0);
        check("fl_grant", 64'(bus.fu_grant), 64'd0);
        check("fl_pop", 64'(bus.rob_pop), 64'd0);
        check("fl_busy0", 64'(bus.busy), 64'd0);
        tick();
        bus.flush_instr = 32'd9;
        sample();
        check("fl_pulse", 64'(bus.rob_flushing_instr), 64'd1);
        check("fl_tag", 64'(bus.rob_instr_to_flush), 64'd5);
        check("fl_busy1", 64'(bus.busy), 64'd1);
        tick();
        bus.flush_req = 0;
        for (int c = 0; c < 2; c++) begin
            sample();
            check("wait_busy", 64'(bus.busy), 64'd1);
            check("wait_pulse", 64'(bus.rob_flushing_instr), 64'd0);
            check("wait_push", 64'(bus.rob_push), 64'd0);
            tick();
        end
        q_push.push_back(32'd20);
        sample();
        check("resume_busy", 64'(bus.busy), 64'd0);
        check("resume_grant", 64'(bus.fu_grant), 64'b0001);
        check("resume_push", 64'(bus.rob_push), 64'd1);
        if (bus.rob_push) begin
            exp_w = q_push.pop_front();
            check("resume_tag", 64'(bus.rob_instr_in), 64'(exp_w));
        end
        check("resume_pop", 64'(bus.rob_pop), 64'd1);
        tick();
        bus.disp_valid = 0; bus.fu_valid = '0; bus.commit_ready = 0;
        sample();
        check("no_second_flush", 64'(bus.rob_flushing_instr), 64'd0);
        check("cm_count2", 64'(bus.commit_count), 64'd2);
        tick();

        // Reset while recovering
        bus.flush_req = 1; bus.flush_instr = 32'd3;
        tick();
        bus.flush_req = 0;
        tick();
        sample();
        check("mid_busy", 64'(bus.busy), 64'd1);
        rst = 1;
        tick();
        rst = 0;
        bus.fu_valid = 4'b1111;
        sample();
        check("rst2_busy", 64'(bus.busy), 64'd0);
        check("rst2_pulse", 64'(bus.rob_flushing_instr), 64'd0);
        check("rst2_count", 64'(bus.commit_count), 64'd0);
        check("rst2_disp_ready", 64'(bus.disp_ready), 64'd1);
        check("rst2_grant", 64'(bus.fu_grant), 64'b0001);
        bus.rob_is_full = 1;
        #1;
        check("rst2_full", 64'(bus.disp_ready), 64'd0);
        tick();
        sample();
        check("rst2_no_pulse", 64'(bus.rob_flushing_instr), 64'd0);

        check("sb_push_empty", 64'(q_push.size()), 64'd0);
        check("sb_grant_empty", 64'(q_grant.size()), 64'd0);
        check("sb_commit_empty", 64'(q_commit.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
